// File: rtl/inport_ctrl.sv
// Input-port buffer controller: tracks flit write/read pointers for one packet
// buffer, routes each stored packet XY-first and drains it on the output's ack.
module inport_ctrl #(
  parameter int PORTS   = 5,
  parameter int DEPTH   = 4,
  parameter int FLITS   = 4,
  parameter int CW      = 3,
  parameter int X_LOCAL = 0,
  parameter int Y_LOCAL = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flit_valid,
  input  logic [CW-1:0]                      dst_x,
  input  logic [CW-1:0]                      dst_y,
  output logic                               wr_en,
  output logic [$clog2(DEPTH*FLITS)-1:0]     wr_addr,
  output logic                               rd_en,
  output logic [$clog2(DEPTH*FLITS)-1:0]     rd_addr,
  output logic [PORTS-1:0]                   port_rqs,
  input  logic [PORTS-1:0]                   ack_in,
  output logic                               credit_out,
  output logic                               err,
  output logic [1:0]                         dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]         dbg_pkt_cnt
);

  localparam int AW   = $clog2(DEPTH*FLITS);
  localparam int FW   = $clog2(FLITS);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] XL = CW'(X_LOCAL);
  localparam logic [CW-1:0] YL = CW'(Y_LOCAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [FW-1:0]     wcnt;
  logic [FW-1:0]     rcnt;
  logic [CNTW-1:0]   pkt_cnt;
  logic [CNTW-1:0]   pkt_cnt_nxt;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PORTS-1:0]  route_mem [DEPTH];
  logic [PORTS-1:0]  route_c;
  logic [PORTS-1:0]  route_head;
  logic [PORTS-1:0]  route_next;
  logic              full;
  logic              hdr_wr;
  logic              last_wr;
  logic              last_rd;
  logic              ack_hit;
  logic              ack_err;

  // XY routing, X dimension resolved first; unsigned compares.
  always_comb begin
    route_c = '0;
    if (dst_x > XL)      route_c[2] = 1'b1;
    else if (dst_x < XL) route_c[4] = 1'b1;
    else if (dst_y > YL) route_c[1] = 1'b1;
    else if (dst_y < YL) route_c[3] = 1'b1;
    else                 route_c[0] = 1'b1;
  end

  // A partial packet always has a free slot reserved, so only a full count blocks.
  assign full    = (pkt_cnt == CNTW'(DEPTH));
  assign wr_en   = flit_valid & ~full;
  assign hdr_wr  = wr_en && (wcnt == '0);
  assign last_wr = wr_en && (wcnt == FW'(FLITS-1));

  // Handshake: port_rqs is held until an ack pulse on a requested bit; that
  // ack cycle is also the first read of the FLITS-cycle crossbar window.
  assign ack_hit = (state == REQ) && |(ack_in & port_rqs);
  assign ack_err = (state == REQ) ? |(ack_in & ~port_rqs) : |ack_in;
  assign last_rd = (state == DRAIN) && (rcnt == FW'(1));
  assign rd_en   = ack_hit | (state == DRAIN);

  assign route_head = route_mem[rptr];
  assign route_next = route_mem[rptr + PW'(1)];

  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    if (last_wr && !last_rd)      pkt_cnt_nxt = pkt_cnt + CNTW'(1);
    else if (!last_wr && last_rd) pkt_cnt_nxt = pkt_cnt - CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      pkt_cnt <= '0;
      wptr    <= '0;
      rptr    <= '0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) route_mem[i] <= '0;
    end else begin
      if (wr_en) begin
        wcnt    <= (wcnt == FW'(FLITS-1)) ? '0 : wcnt + FW'(1);
        wr_addr <= wr_addr + AW'(1);
      end
      if (hdr_wr) begin
        route_mem[wptr] <= route_c;
        wptr            <= wptr + PW'(1);
      end
      if (rd_en)   rd_addr <= rd_addr + AW'(1);
      if (last_rd) rptr    <= rptr + PW'(1);
      pkt_cnt <= pkt_cnt_nxt;
      err     <= err | (flit_valid & full) | ack_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      port_rqs   <= '0;
      rcnt       <= '0;
      credit_out <= 1'b0;
    end else begin
      credit_out <= last_rd;
      case (state)
        IDLE: begin
          if (pkt_cnt != '0) begin
            state    <= REQ;
            port_rqs <= route_head;
          end
        end
        REQ: begin
          if (ack_hit) begin
            state    <= DRAIN;
            port_rqs <= '0;
            rcnt     <= FW'(FLITS-1);
          end
        end
        DRAIN: begin
          rcnt <= rcnt - FW'(1);
          if (rcnt == FW'(1)) begin
            if (pkt_cnt_nxt != '0) begin
              state    <= REQ;
              port_rqs <= route_next;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          port_rqs <= '0;
        end
      endcase
    end
  end

  assign dbg_state   = state;
  assign dbg_pkt_cnt = pkt_cnt;

endmodule
